// File: rtl/hazard_tag_pipe_pkg.sv
// rtl/hazard_tag_pipe_pkg.sv - shared tag types, Tnew classes and mult/div latencies
package hazard_tag_pipe_pkg;

  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef struct packed {
    logic [4:0] a3;
    logic       regwrite;
    logic [1:0] tnew;
  } tag_t;

  // A write to $0 is architecturally a no-op, so it must never look like a hazard.
  function automatic tag_t canon_tag(input logic [4:0] a3, input logic regwrite,
                                     input logic [1:0] tnew);
    tag_t t;
    if (a3 == 5'd0) begin
      t = '0;
    end else begin
      t.a3       = a3;
      t.regwrite = regwrite;
      t.tnew     = tnew;
    end
    return t;
  endfunction

  function automatic logic [1:0] tnew_step(input logic [1:0] tnew);
    return (tnew == TNEW_NONE) ? TNEW_NONE : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe_if.sv
// rtl/hazard_tag_pipe_if.sv - decoder-side inputs and per-stage tag outputs
interface hazard_tag_pipe_if;
  logic       stall;
  logic [4:0] d_a3;
  logic       d_regwrite;
  logic [1:0] d_tnew;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;

  logic [4:0] a3_e;
  logic [4:0] a3_m;
  logic [4:0] a3_w;
  logic       regwrite_e;
  logic       regwrite_m;
  logic       regwrite_w;
  logic [1:0] tnew_e;
  logic [1:0] tnew_m;
  logic       md_busy;
  logic       md_stall;

  modport master (
    output stall, d_a3, d_regwrite, d_tnew, d_md_start, d_md_div, d_md_use,
    input  a3_e, a3_m, a3_w, regwrite_e, regwrite_m, regwrite_w,
    input  tnew_e, tnew_m, md_busy, md_stall
  );

  modport slave (
    input  stall, d_a3, d_regwrite, d_tnew, d_md_start, d_md_div, d_md_use,
    output a3_e, a3_m, a3_w, regwrite_e, regwrite_m, regwrite_w,
    output tnew_e, tnew_m, md_busy, md_stall
  );
endinterface

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div busy window counter
module md_busy_counter #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt;

  // Starts are held off in D while busy, so load never collides with a live count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_tag_pipe.sv
// rtl/hazard_tag_pipe.sv - E/M/W destination tags for the stall/forward unit plus HI/LO stall
module hazard_tag_pipe
  import hazard_tag_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  hazard_tag_pipe_if.slave bus
);

  tag_t       tag_e;
  tag_t       tag_m;
  logic [4:0] a3_w;
  logic       regwrite_w;
  logic       md_start_e;
  logic       md_div_e;
  logic       md_busy;

  // M and W always advance; only E swaps in a bubble when D is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_e      <= '0;
      tag_m      <= '0;
      a3_w       <= '0;
      regwrite_w <= 1'b0;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
    end else begin
      if (bus.stall) begin
        tag_e      <= '0;
        md_start_e <= 1'b0;
        md_div_e   <= 1'b0;
      end else begin
        tag_e      <= canon_tag(bus.d_a3, bus.d_regwrite, bus.d_tnew);
        md_start_e <= bus.d_md_start;
        md_div_e   <= bus.d_md_div;
      end
      tag_m.a3       <= tag_e.a3;
      tag_m.regwrite <= tag_e.regwrite;
      tag_m.tnew     <= tnew_step(tag_e.tnew);
      a3_w           <= tag_m.a3;
      regwrite_w     <= tag_m.regwrite;
    end
  end

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start_e),
    .is_div  (md_div_e),
    .busy    (md_busy)
  );

  assign bus.a3_e       = tag_e.a3;
  assign bus.a3_m       = tag_m.a3;
  assign bus.a3_w       = a3_w;
  assign bus.regwrite_e = tag_e.regwrite;
  assign bus.regwrite_m = tag_m.regwrite;
  assign bus.regwrite_w = regwrite_w;
  assign bus.tnew_e     = tag_e.tnew;
  assign bus.tnew_m     = tag_m.tnew;
  assign bus.md_busy    = md_busy;
  // A start still sitting in E has not loaded the counter yet, so it must block HI/LO users too.
  assign bus.md_stall   = bus.d_md_use & (md_busy | md_start_e);

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb/tb_hazard_tag_pipe.sv - randomized and directed checks of hazard_tag_pipe against a history model
module tb_hazard_tag_pipe;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    int a3;
    int rw;
    int tnew;
    int start;
    int dv;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  hazard_tag_pipe_if bus ();

  hazard_tag_pipe #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   chk_en = 1'b0;
  ent_t hist[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endfunction

  function automatic int exp_busy();
    return (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    ent_t z;
    z = '{0, 0, 0, 0, 0};
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(z);
    busy_lo = 1;
    busy_hi = 0;
  endfunction

  task automatic drive(input int a3, input int rw, input int tnew, input int start,
                       input int dv, input int use_hl, input int rstall);
    int ms;
    if (tnew == 3) $display("note: decoder drove illegal d_tnew=3 for a3=%0d", a3);
    ms = use_hl & ((exp_busy() != 0 || hist[0].start != 0) ? 1 : 0);
    bus.d_a3       = 5'(a3);
    bus.d_regwrite = rw[0];
    bus.d_tnew     = 2'(tnew);
    bus.d_md_start = start[0];
    bus.d_md_div   = dv[0];
    bus.d_md_use   = use_hl[0];
    bus.stall      = rstall[0] | ms[0];
  endtask

  task automatic clock();
    ent_t n;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.stall) begin
      n = '{0, 0, 0, 0, 0};
    end else begin
      n.start = int'(bus.d_md_start);
      n.dv    = int'(bus.d_md_div);
      if (bus.d_a3 == 0) begin
        n.a3 = 0; n.rw = 0; n.tnew = 0;
      end else begin
        n.a3 = int'(bus.d_a3); n.rw = int'(bus.d_regwrite); n.tnew = int'(bus.d_tnew);
      end
    end
    hist.push_front(n);
    void'(hist.pop_back());
    if (n.start != 0) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + (n.dv != 0 ? DC : MC);
    end
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
    clock();
  endtask

  // Model-driven comparison on every cycle once out of reset.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("a3_e", int'(bus.a3_e), hist[0].a3);
      chk("regwrite_e", int'(bus.regwrite_e), hist[0].rw);
      chk("tnew_e", int'(bus.tnew_e), hist[0].tnew);
      chk("a3_m", int'(bus.a3_m), hist[1].a3);
      chk("regwrite_m", int'(bus.regwrite_m), hist[1].rw);
      chk("tnew_m", int'(bus.tnew_m), (hist[1].tnew > 0) ? hist[1].tnew - 1 : 0);
      chk("a3_w", int'(bus.a3_w), hist[2].a3);
      chk("regwrite_w", int'(bus.regwrite_w), hist[2].rw);
      chk("md_busy", int'(bus.md_busy), exp_busy());
      chk("md_stall", int'(bus.md_stall),
          int'(bus.d_md_use) & ((exp_busy() != 0 || hist[0].start != 0) ? 1 : 0));
    end
  end

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst a3_e", int'(bus.a3_e), 0);
    chk("rst regwrite_w", int'(bus.regwrite_w), 0);
    chk("rst tnew_m", int'(bus.tnew_m), 0);
    chk("rst md_busy", int'(bus.md_busy), 0);
    chk("rst md_stall", int'(bus.md_stall), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // lw $8 walking through E, M, W
    drive(8, 1, 2, 0, 0, 0, 0); clock(); #1;
    chk("lw8 a3_e", int'(bus.a3_e), 8);
    chk("lw8 tnew_e", int'(bus.tnew_e), 2);
    nop(); #1;
    chk("lw8 tnew_m", int'(bus.tnew_m), 1);
    nop(); #1;
    chk("lw8 a3_w", int'(bus.a3_w), 8);
    chk("lw8 regwrite_w", int'(bus.regwrite_w), 1);

    // addu $0 canonicalised away
    drive(0, 1, 1, 0, 0, 0, 0); clock(); #1;
    chk("r0 regwrite_e", int'(bus.regwrite_e), 0);
    nop(); #1;
    chk("r0 regwrite_m", int'(bus.regwrite_m), 0);
    nop(); #1;
    chk("r0 regwrite_w", int'(bus.regwrite_w), 0);

    // lw $5 followed by a two-cycle stall
    drive(5, 1, 2, 0, 0, 0, 0); clock();
    drive(6, 1, 1, 0, 0, 0, 1); clock(); #1;
    chk("st1 regwrite_e", int'(bus.regwrite_e), 0);
    chk("st1 a3_m", int'(bus.a3_m), 5);
    chk("st1 tnew_m", int'(bus.tnew_m), 1);
    drive(6, 1, 1, 0, 0, 0, 1); clock(); #1;
    chk("st2 regwrite_e", int'(bus.regwrite_e), 0);
    chk("st2 regwrite_m", int'(bus.regwrite_m), 0);
    chk("st2 a3_w", int'(bus.a3_w), 5);
    nop();

    // ori then link: Tnew saturates at zero
    drive(3, 1, 1, 0, 0, 0, 0); clock();
    drive(31, 1, 0, 0, 0, 0, 0); clock(); #1;
    chk("ori tnew_m", int'(bus.tnew_m), 0);
    nop(); #1;
    chk("link a3_m", int'(bus.a3_m), 31);
    chk("link tnew_m", int'(bus.tnew_m), 0);

    // illegal Tnew passes through unchanged
    drive(7, 1, 3, 0, 0, 0, 0); clock(); #1;
    chk("t3 tnew_e", int'(bus.tnew_e), 3);
    nop(); #1;
    chk("t3 tnew_m", int'(bus.tnew_m), 2);
    nop(); nop();

    // div in E at cycle 0 with mflo waiting in D
    drive(0, 0, 0, 1, 1, 1, 0); clock();
    for (int k = 0; k <= 11; k++) begin
      drive(9, 1, 1, 0, 0, 1, 0); #1;
      chk("div md_stall", int'(bus.md_stall), (k <= 10) ? 1 : 0);
      chk("div md_busy", int'(bus.md_busy), (k >= 1 && k <= 10) ? 1 : 0);
      clock();
    end
    #1;
    chk("mflo enters", int'(bus.a3_e), 9);
    nop(); nop();

    // reset in the middle of a mult
    drive(0, 0, 0, 1, 0, 1, 0); clock();
    nop(); nop(); nop();
    drive(4, 1, 1, 0, 0, 1, 0); #1;
    chk("mid busy", int'(bus.md_busy), 1);
    reset_n = 1'b0; #1;
    chk("arst md_busy", int'(bus.md_busy), 0);
    chk("arst md_stall", int'(bus.md_stall), 0);
    chk("arst a3_m", int'(bus.a3_m), 0);
    chk("arst regwrite_w", int'(bus.regwrite_w), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      int a3, st, uh;
      a3 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
      st = ($urandom_range(0, 9) == 0) ? 1 : 0;
      uh = (st != 0 || $urandom_range(0, 7) == 0) ? 1 : 0;
      drive(a3, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), st,
            int'($urandom_range(0, 1)), uh, ($urandom_range(0, 4) == 0) ? 1 : 0);
      clock();
    end

    nop(); nop();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
